// File: rtl/and_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_pkg
// Description : Shared constants, the result-flag struct and the reduction
//               helper used by the and_gate block.
// Revision    : 1.0  initial release
// ============================================================================
package and_gate_pkg;

    localparam int AND_GATE_MAX_WIDTH = 64;
    localparam int AND_GATE_CNT_W     = 16;

    // Reduction flags carried next to every registered result word.
    typedef struct packed {
        logic all;
        logic any;
    } and_gate_flags_t;

    // WIDTH-agnostic reduction: only the low 'width' bits of val take part,
    // so callers can zero-pad narrower words into the 64-bit argument.
    function automatic and_gate_flags_t and_reduce_flags(
        input logic [AND_GATE_MAX_WIDTH-1:0] val,
        input int                            width
    );
        and_gate_flags_t f;
        f.all = 1'b1;
        f.any = 1'b0;
        for (int i = 0; i < AND_GATE_MAX_WIDTH; i++) begin
            if (i < width) begin
                f.all = f.all & val[i];
                f.any = f.any | val[i];
            end
        end
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/and_gate_outreg.sv
`default_nettype none
// ============================================================================
// Module      : and_gate_outreg
// Description : Generic one-entry valid/ready output register. Accepts a
//               word when empty or when the held word drains in the same
//               edge, giving one word per cycle of throughput.
// Revision    : 1.0  initial release
// ============================================================================
module and_gate_outreg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              w_load;

    // Ready depends only on the held state and downstream ready, never on
    // i_valid, so no combinational loop can form through an upstream.
    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready;

    // Occupancy: load sets it, a drain without a refill clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload: captured on load, otherwise held (also after a drain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/and_gate.sv
`default_nettype none
// ============================================================================
// Module      : and_gate
// Description : Bitwise AND of two WIDTH-bit operands with a live
//               combinational result and a registered result (plus
//               all/any reduction flags) behind a valid/ready register.
//               Optional macro AND_GATE_COUNT_EN adds a saturating 16-bit
//               hit_count of accepted all-ones results.
// Revision    : 1.0  initial release
// ============================================================================
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y_comb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any
`ifdef AND_GATE_COUNT_EN
    ,
    output logic [AND_GATE_CNT_W-1:0] hit_count
`endif
);

    // Result word as held in the output register.
    typedef struct packed {
        logic [WIDTH-1:0] y;
        and_gate_flags_t  flags;
    } res_t;

    localparam int c_res_w = $bits(res_t);

    logic [WIDTH-1:0]              w_and;
    logic [AND_GATE_MAX_WIDTH-1:0] w_pad;
    and_gate_flags_t               w_flags;
    res_t                          w_res_d;
    res_t                          w_res_q;
    logic [c_res_w-1:0]            w_res_q_bits;

    // Per-bit AND: no carries, no dependence on clk or rst.
    assign w_and  = a & b;
    assign y_comb = w_and;

    // Zero-pad into the helper's fixed argument width.
    generate
        if (WIDTH < AND_GATE_MAX_WIDTH) begin : g_pad
            assign w_pad = {{(AND_GATE_MAX_WIDTH-WIDTH){1'b0}}, w_and};
        end else begin : g_nopad
            assign w_pad = w_and;
        end
    endgenerate

    assign w_flags       = and_reduce_flags(w_pad, WIDTH);
    assign w_res_d.y     = w_and;
    assign w_res_d.flags = w_flags;

    and_gate_outreg #(
        .DATA_W (c_res_w)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_res_d),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_res_q_bits)
    );

    assign w_res_q = res_t'(w_res_q_bits);
    assign y       = w_res_q.y;
    assign y_all   = w_res_q.flags.all;
    assign y_any   = w_res_q.flags.any;

`ifdef AND_GATE_COUNT_EN
    localparam logic [AND_GATE_CNT_W-1:0] c_cnt_max = '1;

    logic                      w_accept;
    logic [AND_GATE_CNT_W-1:0] r_hit_count;

    // Same accept condition the output register uses internally.
    assign w_accept = in_valid && in_ready;

    // Saturating count of accepted all-ones results; steps on the edge
    // that registers the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count <= '0;
        end else if (w_accept && w_flags.all && (r_hit_count != c_cnt_max)) begin
            r_hit_count <= r_hit_count + 1'b1;
        end
    end

    assign hit_count = r_hit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_and_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_and_gate
// Description : Self-checking bench for and_gate (WIDTH=8 and WIDTH=1).
//               A queue-based reference model runs beside the WIDTH=8
//               instance and is compared every falling edge; directed steps
//               pin the model with hand-computed literals.
// Revision    : 1.0  initial release
// ============================================================================
module tb_and_gate;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // WIDTH=8 instance
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic [W-1:0] y_comb;
    logic         out_valid;
    logic [W-1:0] y;
    logic         y_all;
    logic         y_any;
`ifdef AND_GATE_COUNT_EN
    logic [15:0]  hit_count;
    logic [15:0]  hit_count1;
`endif

    // WIDTH=1 instance
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic iv1 = 1'b0;
    logic or1 = 1'b1;
    logic ir1;
    logic yc1;
    logic ov1;
    logic y1;
    logic ya1;
    logic yn1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    and_gate #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_comb    (y_comb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_all     (y_all),
        .y_any     (y_any)
`ifdef AND_GATE_COUNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    and_gate #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .y_comb    (yc1),
        .out_valid (ov1),
        .out_ready (or1),
        .y         (y1),
        .y_all     (ya1),
        .y_any     (yn1)
`ifdef AND_GATE_COUNT_EN
        ,
        .hit_count (hit_count1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The output stage is a queue of at most one pending result; the last
    // registered word persists after it drains.
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_last = '0;
    int           m_cnt  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            automatic bit m_acc = in_valid && (m_q.size() == 0 || out_ready);
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_acc) begin
                m_q.push_back(a & b);
                m_last = a & b;
                if ((a & b) == {W{1'b1}} && m_cnt < 65535) m_cnt++;
            end
        end
    end

    // Every falling edge: compare the WIDTH=8 instance to the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_y_comb",    y_comb,    a & b);
            check("m_in_ready",  in_ready,  (m_q.size() == 0) || out_ready);
            check("m_out_valid", out_valid, m_q.size() != 0);
            check("m_y",         y,         m_last);
            check("m_y_all",     y_all,     m_last == {W{1'b1}});
            check("m_y_any",     y_any,     m_last != '0);
`ifdef AND_GATE_COUNT_EN
            check("m_hit_count", hit_count, m_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] w1_tab;

    initial begin
        // Reset state
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_y",         y,         0);
        check("rst_y_all",     y_all,     0);
        check("rst_y_any",     y_any,     0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // F0 & 3C
        a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("d1_y_comb", y_comb, 8'h30);
        tick();
        check("d1_y",     y,     8'h30);
        check("d1_y_all", y_all, 0);
        check("d1_y_any", y_any, 1);
        check("d1_valid", out_valid, 1);

        // all ones, then zero result
        a = 8'hFF; b = 8'hFF;
        tick();
        check("d2_y",     y,     8'hFF);
        check("d2_y_all", y_all, 1);
        a = 8'h00; b = 8'hFF;
        tick();
        check("d3_y",     y,     8'h00);
        check("d3_y_any", y_any, 0);

        // Backpressure
        a = 8'hF0; b = 8'h3C;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom);
            #1 check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_y_hold", y, 8'h30);
        end
        a = 8'h0F; b = 8'h0F; out_ready = 1'b1;
        tick();
        check("bp_y_new",  y,         8'h0F);
        check("bp_valid",  out_valid, 1);

        // Asynchronous reset between edges
        a = 8'hFF; b = 8'hFF;
        tick();
        check("ar_pre_y", y, 8'hFF);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_valid",  out_valid, 0);
        check("ar_y",      y,         0);
        check("ar_y_all",  y_all,     0);
        check("ar_y_any",  y_any,     0);
        check("ar_y_comb", y_comb,    8'hFF);
        a = 8'h5A;
        #1 check("ar_y_comb2", y_comb, 8'h5A);
        rst = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a         = W'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
            if ($urandom_range(0, 3) == 0) a = 8'hFF;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // WIDTH=1 truth table
        w1_tab = 4'b1000;
        iv1 = 1'b1; or1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            #1 check("w1_y_comb", yc1, w1_tab[i]);
            tick();
            check("w1_y",     y1,  w1_tab[i]);
            check("w1_y_all", ya1, w1_tab[i]);
            check("w1_y_any", yn1, w1_tab[i]);
            check("w1_valid", ov1, 1);
        end
        iv1 = 1'b0;

`ifdef AND_GATE_COUNT_EN
        // Counter: 3 hits, 2 misses
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        in_valid = 1'b1; out_ready = 1'b1;
        a = 8'hFF; b = 8'hFF;
        repeat (3) tick();
        a = 8'h0F;
        repeat (2) tick();
        in_valid = 1'b0;
        tick();
        check("cnt_three", hit_count, 16'd3);
        // Saturation
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        repeat (70000) tick();
        in_valid = 1'b0;
        tick();
        check("cnt_sat", hit_count, 16'hFFFF);
`endif

        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
